// File: rtl/fp_convert_ctrl_pkg.sv
// Shared types and constants for the 12-bit integer to 8-bit float converter.
package fp_convert_ctrl_pkg;

   localparam int IN_W  = 12;
   localparam int MAG_W = IN_W - 1;
   localparam int EXP_W = 3;
   localparam int SIG_W = 4;

   localparam logic [EXP_W-1:0] E_MAX    = 3'd7;
   localparam logic [SIG_W-1:0] F_MAX    = 4'hF;
   localparam logic [SIG_W-1:0] F_CARRY  = 4'b1000;
   localparam logic [EXP_W-1:0] EXP_INIT = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   // |d| on MAG_W bits; the most negative input has no positive twin, so clamp it.
   function automatic logic [MAG_W-1:0] abs_sat(input logic [IN_W-1:0] d);
      logic [IN_W-1:0] neg;
      neg = (~d) + 1'b1;
      if (!d[IN_W-1])
         return d[MAG_W-1:0];
      else if (d[MAG_W-1:0] == '0)
         return {MAG_W{1'b1}};
      else
         return neg[MAG_W-1:0];
   endfunction

endpackage

// File: rtl/fp_convert_ctrl_if.sv
// Sample-in / float-out handshake bundle between source, converter and consumer.
interface fp_convert_ctrl_if;
   import fp_convert_ctrl_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  D;
   logic             out_valid;
   logic             out_ready;
   logic             S;
   logic [EXP_W-1:0] E;
   logic [SIG_W-1:0] F;

   // converter side
   modport slave (
      input  in_valid, D, out_ready,
      output in_ready, out_valid, S, E, F
   );

   // source/consumer side
   modport master (
      output in_valid, D, out_ready,
      input  in_ready, out_valid, S, E, F
   );

endinterface

// File: rtl/fp_convert_ctrl_round.sv
// Round-half-up of the 4-bit significand with exponent carry and saturation.
module fp_round
   import fp_convert_ctrl_pkg::*;
(
   input  logic [EXP_W-1:0] exp,
   input  logic [SIG_W-1:0] f,
   input  logic             fifth,
   output logic [EXP_W-1:0] e_out,
   output logic [SIG_W-1:0] f_out
);

   logic [SIG_W:0] sum;

   assign sum = {1'b0, f} + {{SIG_W{1'b0}}, fifth};

   always_comb begin
      e_out = exp;
      f_out = sum[SIG_W-1:0];
      if (sum[SIG_W]) begin
         // 1111+1 renormalizes to 1000 one exponent up, unless already at the top.
         if (exp == E_MAX) begin
            e_out = E_MAX;
            f_out = F_MAX;
         end else begin
            e_out = exp + 1'b1;
            f_out = F_CARRY;
         end
      end
   end

endmodule

// File: rtl/fp_convert_ctrl.sv
// Iterative normalizer: one left shift per cycle until the MSB is set or exp hits 0.
module fp_convert_ctrl
   import fp_convert_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   fp_convert_ctrl_if.slave  bus
);

   state_t           state_q, state_d;
   logic [MAG_W-1:0] mag_q, mag_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic             sign_q, sign_d;
   logic             load_out;
   logic             clr_valid;

   logic [SIG_W-1:0] f_raw;
   logic             fifth;
   logic [EXP_W-1:0] e_rnd;
   logic [SIG_W-1:0] f_rnd;

   assign bus.in_ready = (state_q == IDLE);

   // At exp=0 the window already sits on the low bits and nothing lies below it.
   assign f_raw = mag_q[MAG_W-1 -: SIG_W];
   assign fifth = (exp_q != '0) ? mag_q[MAG_W-1-SIG_W] : 1'b0;

   fp_round u_round (
      .exp   (exp_q),
      .f     (f_raw),
      .fifth (fifth),
      .e_out (e_rnd),
      .f_out (f_rnd)
   );

   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      exp_d     = exp_q;
      sign_d    = sign_q;
      load_out  = 1'b0;
      clr_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sign_d  = bus.D[IN_W-1];
               mag_d   = abs_sat(bus.D);
               exp_d   = EXP_INIT;
               state_d = NORM;
            end
         end
         NORM: begin
            if (mag_q[MAG_W-1] || exp_q == '0) begin
               state_d = ROUND;
            end else begin
               mag_d = {mag_q[MAG_W-2:0], 1'b0};
               exp_d = exp_q - 1'b1;
            end
         end
         ROUND: begin
            load_out = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               clr_valid = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mag_q   <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
      end
   end

   // Result registers change only on ROUND, so they stay put through DONE and IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.S         <= 1'b0;
         bus.E         <= '0;
         bus.F         <= '0;
         bus.out_valid <= 1'b0;
      end else if (load_out) begin
         bus.S         <= sign_q;
         bus.E         <= e_rnd;
         bus.F         <= f_rnd;
         bus.out_valid <= 1'b1;
      end else if (clr_valid) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// Directed table, reference-model random run and reset/backpressure sequences.
module tb_fp_convert_ctrl;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   fp_convert_ctrl_if bus ();

   fp_convert_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] d;
      int          s;
      int          e;
      int          f;
      int          lat;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Value-level model: pick E so the value fits 4 bits, round half up, clamp at the top.
   task automatic model(input logic [11:0] d, output int s, output int e,
                        output int f, output int lat);
      int x, mag, msb;
      x   = $signed(d);
      s   = (x < 0) ? 1 : 0;
      mag = (x < 0) ? -x : x;
      if (mag > 2047) mag = 2047;
      msb = -1;
      for (int i = 0; i < 11; i++) if (((mag >> i) & 1) != 0) msb = i;
      lat = ((10 - msb) < 7 ? (10 - msb) : 7) + 2;
      if (mag < 16) begin
         e = 0;
         f = mag;
      end else begin
         e = msb - 3;
         f = (mag + (1 << (e - 1))) >> e;
         if (f == 16) begin
            f = 8;
            e = e + 1;
         end
         if (e > 7) begin
            e = 7;
            f = 15;
         end
      end
   endtask

   // Issue one sample, measure latency, check result, apply `hold` cycles of backpressure.
   task automatic convert(input string tag, input logic [11:0] d, input int hold,
                          input int es, input int ee, input int ef, input int elat);
      int lat;
      @(negedge clk);
      chk({tag, " in_ready idle"}, int'(bus.in_ready), 1);
      bus.in_valid  = 1'b1;
      bus.D         = d;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.D        = 12'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " latency"}, lat, elat);
      @(negedge clk);
      chk({tag, " S"}, int'(bus.S), es);
      chk({tag, " E"}, int'(bus.E), ee);
      chk({tag, " F"}, int'(bus.F), ef);
      chk({tag, " in_ready busy"}, int'(bus.in_ready), 0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk({tag, " hold valid"}, int'(bus.out_valid), 1);
         chk({tag, " hold SEF"}, int'({bus.S, bus.E, bus.F}), (es << 7) | (ee << 4) | ef);
         chk({tag, " hold in_ready"}, int'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, " valid cleared"}, int'(bus.out_valid), 0);
      chk({tag, " back to idle"}, int'(bus.in_ready), 1);
   endtask

   initial begin
      int s, e, f, lat;
      logic [11:0] d;

      vecs[0] = '{12'd44,   0, 2, 11, 7};
      vecs[1] = '{12'hFD4,  1, 2, 11, 7};
      vecs[2] = '{12'd124,  0, 4,  8, 6};
      vecs[3] = '{12'h800,  1, 7, 15, 2};
      vecs[4] = '{12'd2047, 0, 7, 15, 2};
      vecs[5] = '{12'd0,    0, 0,  0, 9};
      vecs[6] = '{12'd5,    0, 0,  5, 9};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.D         = '0;
      bus.out_ready = 1'b0;
      #1;
      chk("reset out_valid", int'(bus.out_valid), 0);
      chk("reset SEF", int'({bus.S, bus.E, bus.F}), 0);
      chk("reset in_ready", int'(bus.in_ready), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++)
         convert($sformatf("vec%0d", i), vecs[i].d, 0,
                 vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].lat);

      // backpressure: result frozen for 5 cycles
      convert("hold44", 12'd44, 5, 0, 2, 11, 7);

      for (int n = 0; n < 150; n++) begin
         d = 12'($urandom);
         // bias toward small magnitudes so the exp=0 and short-shift paths get traffic
         if (n % 3 == 0) d = 12'($signed(d) >>> $urandom_range(4, 11));
         model(d, s, e, f, lat);
         convert($sformatf("rnd%0d d=%h", n, d), d, int'($urandom_range(0, 2)), s, e, f, lat);
      end

      // leave a nonzero result in the output registers, then reset mid-NORM
      convert("pre_rst", 12'd2047, 0, 0, 7, 15, 2);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.D        = 12'd5;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_norm in_ready", int'(bus.in_ready), 0);
      rst_n = 1'b0;
      #1;
      chk("rst out_valid", int'(bus.out_valid), 0);
      chk("rst SEF", int'({bus.S, bus.E, bus.F}), 0);
      chk("rst in_ready", int'(bus.in_ready), 1);
      #2;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst no result", int'(bus.out_valid), 0);
      convert("post_rst", 12'hFD4, 0, 1, 2, 11, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
